bus_arb_mux: RTL and testbench

BUS_ARB_MUX -- requirements
Module: bus_arb_mux

---
 rtl/bus_arb_mux_if.sv | 26 ++
 rtl/bus_arb_mux.sv | 88 ++++++++
 tb/tb_bus_arb_mux.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/bus_arb_mux_if.sv
// Handshake bundle between N requesting channels, the arbiter/mux, and its single downstream consumer.
interface bus_arb_mux_if #(
  parameter int WIDTH  = 4,
  parameter int NUM_CH = 4
);
  localparam int CW = $clog2(NUM_CH);

  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [CW-1:0]           sel;
  logic [WIDTH-1:0]        out_data;
  logic [CW-1:0]           out_ch;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/bus_arb_mux.sv
// N:1 arbitrating mux (round-robin / fixed priority / external select) into a one-word output register.
// Latency 1 cycle; full throughput; out_ready low holds the word and drops every in_ready.
module bus_arb_mux #(
  parameter int WIDTH  = 4,
  parameter int NUM_CH = 4,
  parameter int MODE   = 0
) (
  input logic          clk,
  input logic          rst_n,
  bus_arb_mux_if.slave bus
);
  localparam int CW = $clog2(NUM_CH);

  logic [NUM_CH-1:0] grant;
  logic [CW-1:0]     g_idx;
  logic [CW-1:0]     rr_ptr;
  logic [WIDTH-1:0]  g_data;
  logic              found;
  logic              load_en;
  logic              xfer;
  logic [WIDTH-1:0]  out_data_q;
  logic [CW-1:0]     out_ch_q;
  logic              out_valid_q;
  int                idx;

  always_comb begin
    found = 1'b0;
    g_idx = '0;
    idx   = 0;
    if (MODE == 0) begin
      // Descending scan so the candidate closest to rr_ptr is the last one written.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        idx = (int'(rr_ptr) + k) % NUM_CH;
        if (bus.in_valid[idx]) begin
          found = 1'b1;
          g_idx = CW'(idx);
        end
      end
    end else if (MODE == 1) begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (bus.in_valid[k]) begin
          found = 1'b1;
          g_idx = CW'(k);
        end
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (CW'(k) == bus.sel && bus.in_valid[k]) begin
          found = 1'b1;
          g_idx = CW'(k);
        end
      end
    end

    grant  = '0;
    g_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (found && CW'(k) == g_idx) begin
        grant[k] = 1'b1;
        g_data   = bus.in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign load_en      = !out_valid_q | bus.out_ready;
  assign xfer         = found & load_en;
  assign bus.in_ready = grant & {NUM_CH{load_en & rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr      <= '0;
    end else if (xfer) begin
      out_data_q  <= g_data;
      out_ch_q    <= g_idx;
      out_valid_q <= 1'b1;
      if (MODE == 0) rr_ptr <= CW'((int'(g_idx) + 1) % NUM_CH);
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_bus_arb_mux.sv
// Directed and randomized checks of bus_arb_mux in all three arbitration modes, one instance per mode.
module tb_bus_arb_mux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bus_arb_mux_if #(.WIDTH(4), .NUM_CH(4)) b0 ();
  bus_arb_mux_if #(.WIDTH(4), .NUM_CH(4)) b1 ();
  bus_arb_mux_if #(.WIDTH(4), .NUM_CH(4)) b2 ();

  bus_arb_mux #(.WIDTH(4), .NUM_CH(4), .MODE(0)) u_rr  (.clk(clk), .rst_n(rst_n), .bus(b0));
  bus_arb_mux #(.WIDTH(4), .NUM_CH(4), .MODE(1)) u_fix (.clk(clk), .rst_n(rst_n), .bus(b1));
  bus_arb_mux #(.WIDTH(4), .NUM_CH(4), .MODE(2)) u_sel (.clk(clk), .rst_n(rst_n), .bus(b2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    b0.in_data = 16'hDCBA; b0.in_valid = 4'b1111; b0.sel = 2'd0; b0.out_ready = 1'b1;
    b1.in_data = 16'h0;    b1.in_valid = 4'b0000; b1.sel = 2'd0; b1.out_ready = 1'b1;
    b2.in_data = 16'h0;    b2.in_valid = 4'b0000; b2.sel = 2'd0; b2.out_ready = 1'b1;
    #3;
    n_cmp++; if (b0.in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0000", b0.in_ready); end
    n_cmp++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", b0.out_valid); end
    n_cmp++; if (b0.out_data !== 4'h0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", b0.out_data); end
    n_cmp++; if (b0.out_ch !== 2'd0) begin n_fail++; $display("FAIL reset_out_ch got=%0d exp=0", b0.out_ch); end
    n_cmp++; if ({b1.out_valid, b2.out_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_out_valid_m12 got=%b exp=00", {b1.out_valid, b2.out_valid}); end
    tick();
    n_cmp++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_held_no_load got=%b exp=0", b0.out_valid); end
    rst_n = 1'b1;
  endtask

  // Round-robin sweep; first transfer lands on the first edge after reset release.
  task automatic test_round_robin();
    logic [3:0] exp_d;
    #1;
    n_cmp++; if (b0.in_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_first_ready got=%b exp=0001", b0.in_ready); end
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_d = 4'hA + 4'(i % 4);
      n_cmp++; if (b0.out_valid !== 1'b1 || b0.out_ch !== 2'(i % 4) || b0.out_data !== exp_d) begin
        n_fail++; $display("FAIL rr_seq[%0d] got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h", i, b0.out_valid, b0.out_ch, b0.out_data, i % 4, exp_d);
      end
    end
  endtask

  task automatic test_backpressure();
    b0.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (b0.in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d] got=%b exp=0000", i, b0.in_ready); end
      tick();
      n_cmp++; if (b0.out_valid !== 1'b1 || b0.out_ch !== 2'd0 || b0.out_data !== 4'hA) begin
        n_fail++; $display("FAIL bp_hold[%0d] got v=%b ch=%0d d=%h exp v=1 ch=0 d=a", i, b0.out_valid, b0.out_ch, b0.out_data);
      end
    end
    b0.out_ready = 1'b1;
    #1;
    n_cmp++; if (b0.in_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=0010", b0.in_ready); end
    tick();
    n_cmp++; if (b0.out_ch !== 2'd1 || b0.out_data !== 4'hB) begin n_fail++; $display("FAIL bp_release_load got ch=%0d d=%h exp ch=1 d=b", b0.out_ch, b0.out_data); end
    b0.in_valid = 4'b0000;
    tick();
    n_cmp++; if (b0.out_valid !== 1'b0 || b0.out_data !== 4'hB) begin n_fail++; $display("FAIL bp_drain got v=%b d=%h exp v=0 d=b", b0.out_valid, b0.out_data); end
  endtask

  task automatic test_fixed_priority();
    b1.in_data = 16'h0970; b1.in_valid = 4'b0110; b1.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (b1.in_ready !== 4'b0010) begin n_fail++; $display("FAIL fix_ready[%0d] got=%b exp=0010", i, b1.in_ready); end
      tick();
      n_cmp++; if (b1.out_valid !== 1'b1 || b1.out_ch !== 2'd1 || b1.out_data !== 4'h7) begin
        n_fail++; $display("FAIL fix_out[%0d] got v=%b ch=%0d d=%h exp v=1 ch=1 d=7", i, b1.out_valid, b1.out_ch, b1.out_data);
      end
    end
    b1.in_valid = 4'b0100;
    #1;
    n_cmp++; if (b1.in_ready !== 4'b0100) begin n_fail++; $display("FAIL fix_alone_ready got=%b exp=0100", b1.in_ready); end
    tick();
    n_cmp++; if (b1.out_ch !== 2'd2 || b1.out_data !== 4'h9) begin n_fail++; $display("FAIL fix_alone_out got ch=%0d d=%h exp ch=2 d=9", b1.out_ch, b1.out_data); end
    b1.in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_select();
    b2.in_data = 16'h0500; b2.in_valid = 4'b0100; b2.sel = 2'd2; b2.out_ready = 1'b1;
    #1;
    n_cmp++; if (b2.in_ready !== 4'b0100) begin n_fail++; $display("FAIL sel_ready got=%b exp=0100", b2.in_ready); end
    tick();
    n_cmp++; if (b2.out_valid !== 1'b1 || b2.out_ch !== 2'd2 || b2.out_data !== 4'h5) begin
      n_fail++; $display("FAIL sel_out got v=%b ch=%0d d=%h exp v=1 ch=2 d=5", b2.out_valid, b2.out_ch, b2.out_data);
    end
    b2.sel = 2'd3;
    #1;
    n_cmp++; if (b2.in_ready !== 4'b0000) begin n_fail++; $display("FAIL sel_invalid_ready got=%b exp=0000", b2.in_ready); end
    tick();
    n_cmp++; if (b2.out_valid !== 1'b0 || b2.out_ch !== 2'd2) begin n_fail++; $display("FAIL sel_drain got v=%b ch=%0d exp v=0 ch=2", b2.out_valid, b2.out_ch); end
    b2.in_valid = 4'b0000;
  endtask

  // rr_ptr sits at 3 when reset hits, so an all-valid grant of channel 0 proves it was cleared.
  task automatic test_async_reset();
    b0.in_data = 16'hDCBA; b0.in_valid = 4'b1111; b0.out_ready = 1'b0;
    tick();
    n_cmp++; if (b0.out_valid !== 1'b1 || b0.out_ch !== 2'd2 || b0.out_data !== 4'hC) begin
      n_fail++; $display("FAIL ar_preload got v=%b ch=%0d d=%h exp v=1 ch=2 d=c", b0.out_valid, b0.out_ch, b0.out_data);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (b0.out_valid !== 1'b0 || b0.out_data !== 4'h0 || b0.out_ch !== 2'd0 || b0.in_ready !== 4'b0000) begin
      n_fail++; $display("FAIL ar_immediate got v=%b d=%h ch=%0d rdy=%b exp v=0 d=0 ch=0 rdy=0000", b0.out_valid, b0.out_data, b0.out_ch, b0.in_ready);
    end
    b0.out_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    n_cmp++; if (b0.in_ready !== 4'b0001) begin n_fail++; $display("FAIL ar_ptr_cleared got=%b exp=0001", b0.in_ready); end
    b0.in_valid = 4'b1000;
    #1;
    n_cmp++; if (b0.in_ready !== 4'b1000) begin n_fail++; $display("FAIL ar_single_ready got=%b exp=1000", b0.in_ready); end
    tick();
    n_cmp++; if (b0.out_valid !== 1'b1 || b0.out_ch !== 2'd3 || b0.out_data !== 4'hD) begin
      n_fail++; $display("FAIL ar_single_out got v=%b ch=%0d d=%h exp v=1 ch=3 d=d", b0.out_valid, b0.out_ch, b0.out_data);
    end
    b0.in_valid = 4'b0000;
    tick();
  endtask

  // Scoreboard: words accepted via handshake must leave once each, in order, with their channel.
  task automatic test_random();
    logic [5:0]  q[3][$];
    logic [3:0]  iv, ir;
    logic [15:0] id;
    logic        ov, ordy;
    logic [1:0]  och;
    logic [3:0]  od;
    logic [5:0]  w;
    for (int cyc = 0; cyc < 400; cyc++) begin
      b0.in_valid = (cyc < 390) ? 4'($urandom) : 4'b0000; b0.in_data = 16'($urandom); b0.out_ready = (cyc < 390) ? ($urandom_range(0, 3) != 0) : 1'b1;
      b1.in_valid = (cyc < 390) ? 4'($urandom) : 4'b0000; b1.in_data = 16'($urandom); b1.out_ready = (cyc < 390) ? ($urandom_range(0, 3) != 0) : 1'b1;
      b2.in_valid = (cyc < 390) ? 4'($urandom) : 4'b0000; b2.in_data = 16'($urandom); b2.out_ready = (cyc < 390) ? ($urandom_range(0, 3) != 0) : 1'b1;
      b2.sel = 2'($urandom);
      #1;
      for (int b = 0; b < 3; b++) begin
        case (b)
          0:       begin iv = b0.in_valid; ir = b0.in_ready; id = b0.in_data; ov = b0.out_valid; ordy = b0.out_ready; och = b0.out_ch; od = b0.out_data; end
          1:       begin iv = b1.in_valid; ir = b1.in_ready; id = b1.in_data; ov = b1.out_valid; ordy = b1.out_ready; och = b1.out_ch; od = b1.out_data; end
          default: begin iv = b2.in_valid; ir = b2.in_ready; id = b2.in_data; ov = b2.out_valid; ordy = b2.out_ready; och = b2.out_ch; od = b2.out_data; end
        endcase
        n_cmp++; if ((ir & ~iv) != 4'b0000 || !$onehot0(ir) || (ov && !ordy && ir != 4'b0000)) begin
          n_fail++; $display("FAIL rnd_ready m%0d cyc=%0d got rdy=%b vld=%b ov=%b ordy=%b", b, cyc, ir, iv, ov, ordy);
        end
        n_cmp++; if (ov !== (q[b].size() != 0)) begin
          n_fail++; $display("FAIL rnd_occupancy m%0d cyc=%0d got ov=%b exp=%b", b, cyc, ov, q[b].size() != 0);
        end
        if (ov && ordy && q[b].size() != 0) begin
          w = q[b].pop_front();
          n_cmp++; if ({och, od} !== w) begin
            n_fail++; $display("FAIL rnd_word m%0d cyc=%0d got ch=%0d d=%h exp ch=%0d d=%h", b, cyc, och, od, w[5:4], w[3:0]);
          end
        end
        for (int c = 0; c < 4; c++) begin
          if (ir[c] && iv[c]) q[b].push_back({2'(c), id[c*4 +: 4]});
        end
      end
      tick();
    end
    for (int b = 0; b < 3; b++) begin
      n_cmp++; if (q[b].size() != 0) begin n_fail++; $display("FAIL rnd_leftover m%0d got=%0d exp=0", b, q[b].size()); end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_fixed_priority();
    test_select();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
